// File: rtl/neuron_param_loader_pkg.sv
// Shared types and default sizing for the neuron parameter loader.
// Holds the FSM state encoding and frame-geometry helpers.
package neuron_param_loader_pkg;

  localparam int K_DEF   = 4;
  localparam int N_DEF   = 4;
  localparam int B_DEF   = 4;
  localparam int M_DEF   = 4;
  localparam int W_DEF   = 4;
  localparam int GAP_DEF = 2;

  localparam int FRAME_WORDS = 2*M_DEF + 1;
  localparam int IDX_W       = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    GAP     = 2'd2,
    DROP    = 2'd3
  } state_e;

  function automatic int frame_words(input int mm);
    return 2*mm + 1;
  endfunction

  function automatic int idx_width(input int mm);
    return $clog2(2*mm + 1);
  endfunction

endpackage

// File: rtl/neuron_param_loader.sv
// Assembles m activations, m weights and a bias from a word stream
// and presents them to the neuron with a one-cycle load_params strobe.
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   in_data/valid/last   input word stream; in_ready = accept
//   activation_input     m*k packed activations (elem i at [i*k +: k])
//   weight               m*n packed weights     (elem j at [j*n +: n])
//   bias                 b-bit bias
//   load_params          one-cycle load strobe
//   frame_err            one-cycle framing-error pulse
//   frame_cnt            frames loaded, wraps
module neuron_param_loader
  import neuron_param_loader_pkg::*;
#(
  parameter int k          = K_DEF,
  parameter int n          = N_DEF,
  parameter int b          = B_DEF,
  parameter int m          = M_DEF,
  parameter int W          = W_DEF,
  parameter int GAP_CYCLES = GAP_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [m*k-1:0] activation_input,
  output logic [m*n-1:0] weight,
  output logic [b-1:0]   bias,
  output logic           load_params,
  output logic           frame_err,
  output logic [15:0]    frame_cnt
);

  localparam int IW = idx_width(m);
  localparam logic [IW-1:0] LAST_IDX = IW'(frame_words(m) - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ready_q, ready_d;
  logic            load_q, load_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [m*k-1:0]  act_sh_q, act_q;
  logic [m*n-1:0]  wt_sh_q, wt_q;
  logic [b-1:0]    bias_q;

  logic            acc;
  logic            wr;
  logic            fire;

  assign acc = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    wr      = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (acc) begin
          if (idx_q != LAST_IDX) begin
            if (in_last) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              wr    = 1'b1;
              idx_d = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            if (in_last) begin
              fire    = 1'b1;
              load_d  = 1'b1;
              cnt_d   = cnt_q + 16'd1;
              state_d = LOAD;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end
        end
      end
      LOAD: begin
        gap_d   = GAP_INIT;
        state_d = (GAP_CYCLES > 0) ? GAP : COLLECT;
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = COLLECT;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DROP: begin
        if (acc && in_last) begin
          state_d = COLLECT;
        end
      end
    endcase
    // Registered ready: follows the state being entered, so it
    // stays low throughout reset and never sees input timing.
    ready_d = (state_d == COLLECT) || (state_d == DROP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_sh_q <= '0;
      wt_sh_q  <= '0;
      act_q    <= '0;
      wt_q     <= '0;
      bias_q   <= '0;
    end else begin
      if (wr) begin
        for (int i = 0; i < m; i++) begin
          if (idx_q == IW'(i)) begin
            act_sh_q[i*k +: k] <= in_data[k-1:0];
          end
          if (idx_q == IW'(m + i)) begin
            wt_sh_q[i*n +: n] <= in_data[n-1:0];
          end
        end
      end
      // Bias goes straight to the output; it is the last word.
      if (fire) begin
        act_q  <= act_sh_q;
        wt_q   <= wt_sh_q;
        bias_q <= in_data[b-1:0];
      end
    end
  end

  assign in_ready         = ready_q;
  assign activation_input = act_q;
  assign weight           = wt_q;
  assign bias             = bias_q;
  assign load_params      = load_q;
  assign frame_err        = err_q;
  assign frame_cnt        = cnt_q;

endmodule
